// File: rtl/wired_mdu_unit_pkg.sv
// Shared types for the MDU execution unit: op codes, request/response payloads, FSM states.
package wired_mdu_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ROB_ID_W = 6;

  localparam logic [1:0] MDU_MUL  = 2'b00;
  localparam logic [1:0] MDU_MULH = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;
  localparam logic [1:0] MDU_MOD  = 2'b11;

  typedef logic [ROB_ID_W-1:0] rob_rid_t;

  typedef struct packed {
    logic [1:0]      op;
    logic [XLEN-1:0] r0;
    logic [XLEN-1:0] r1;
    rob_rid_t        wid;
  } iq_mdu_req_t;

  typedef struct packed {
    rob_rid_t        wid;
    logic [XLEN-1:0] result;
  } iq_mdu_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_PREP,
    ST_DIV_ITER,
    ST_DIV_FIX,
    ST_DONE
  } mdu_state_e;

endpackage

// File: rtl/wired_mdu_div.sv
// Iterative unsigned restoring divider core; resolves BITS_PER_ITER quotient bits per cycle.
module wired_mdu_div #(
  parameter int unsigned BITS_PER_ITER = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done_c,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem
);

  localparam int unsigned ITERS = 32 / BITS_PER_ITER;
  localparam int unsigned CNT_W = 6;

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_quo;
  logic [31:0]      r_rem;
  logic [31:0]      r_dvs;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;
  logic [32:0]      w_sh;

  // One iteration: shift in the next dividend bit(s), subtract when the divisor fits.
  always_comb begin
    w_quo = r_quo;
    w_rem = r_rem;
    w_sh  = '0;
    for (int unsigned k = 0; k < BITS_PER_ITER; k++) begin
      w_sh  = {w_rem, w_quo[31]};
      w_quo = {w_quo[30:0], 1'b0};
      if (w_sh >= {1'b0, r_dvs}) begin
        w_sh     = w_sh - {1'b0, r_dvs};
        w_quo[0] = 1'b1;
      end
      w_rem = w_sh[31:0];
    end
  end

  // Iteration counter and partial quotient/remainder registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(ITERS);
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (r_cnt != '0) begin
      r_quo <= w_quo;
      r_rem <= w_rem;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy   = (r_cnt != '0);
  assign o_done_c = (r_cnt == CNT_W'(1));
  assign o_quo    = r_quo;
  assign o_rem    = r_rem;

endmodule

// File: rtl/wired_mdu_unit.sv
// MDU execution unit: fixed-latency signed multiply, iterative signed divide/modulo, one op in flight.
module wired_mdu_unit
  import wired_mdu_unit_pkg::*;
#(
  parameter int unsigned DIV_BITS_PER_ITER = 1,
  parameter int unsigned MUL_LATENCY       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  iq_mdu_req_t  req_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output iq_mdu_resp_t resp_o
);

  mdu_state_e   r_state;
  logic [1:0]   r_op;
  logic [31:0]  r_a;
  logic [31:0]  r_b;
  rob_rid_t     r_wid;
  logic [1:0]   r_mcnt;
  logic [63:0]  r_stage [MUL_LATENCY-1];
  logic         r_q_neg;
  logic         r_r_neg;
  logic         r_special;
  logic [31:0]  r_spec_q;
  logic [31:0]  r_spec_r;
  logic         r_resp_valid;
  iq_mdu_resp_t r_resp;

  logic [63:0]  w_prod;
  logic [31:0]  w_abs_a;
  logic [31:0]  w_abs_b;
  logic         w_div_zero;
  logic         w_div_ovf;
  logic         w_div_start;
  logic         w_div_busy;
  logic         w_div_done_c;
  logic [31:0]  w_div_quo;
  logic [31:0]  w_div_rem;
  logic [31:0]  w_fix_quo;
  logic [31:0]  w_fix_rem;

  // Full 64-bit signed product of the latched operands.
  assign w_prod = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});

  // Divide preparation: magnitudes and the two architecturally defined corner cases.
  assign w_abs_a     = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_abs_b     = r_b[31] ? (~r_b + 32'd1) : r_b;
  assign w_div_zero  = (r_b == 32'd0);
  assign w_div_ovf   = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_div_start = (r_state == ST_DIV_PREP) && !flush_i && !w_div_zero && !w_div_ovf;

  // Sign restoration: quotient negative when operand signs differ, remainder follows the dividend.
  assign w_fix_quo = r_q_neg ? (~w_div_quo + 32'd1) : w_div_quo;
  assign w_fix_rem = r_r_neg ? (~w_div_rem + 32'd1) : w_div_rem;

  wired_mdu_div #(
    .BITS_PER_ITER (DIV_BITS_PER_ITER)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (flush_i),
    .i_start    (w_div_start),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_busy     (w_div_busy),
    .o_done_c   (w_div_done_c),
    .o_quo      (w_div_quo),
    .o_rem      (w_div_rem)
  );

  // Control FSM with registered response; flush beats any handshake in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_wid        <= '0;
      r_mcnt       <= '0;
      r_q_neg      <= 1'b0;
      r_r_neg      <= 1'b0;
      r_special    <= 1'b0;
      r_spec_q     <= '0;
      r_spec_r     <= '0;
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY - 1; i++) begin
        r_stage[i] <= '0;
      end
    end else if (flush_i) begin
      r_state      <= ST_IDLE;
      r_resp_valid <= 1'b0;
      r_mcnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_op    <= req_i.op;
            r_a     <= req_i.r0;
            r_b     <= req_i.r1;
            r_wid   <= req_i.wid;
            r_mcnt  <= '0;
            r_state <= req_i.op[1] ? ST_DIV_PREP : ST_MUL;
          end
        end
        ST_MUL: begin
          r_stage[0] <= w_prod;
          for (int unsigned i = 1; i < MUL_LATENCY - 1; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
          r_mcnt <= r_mcnt + 2'd1;
          if (r_mcnt == 2'(MUL_LATENCY - 1)) begin
            r_resp_valid  <= 1'b1;
            r_resp.wid    <= r_wid;
            r_resp.result <= (r_op == MDU_MULH) ? r_stage[MUL_LATENCY-2][63:32]
                                                : r_stage[MUL_LATENCY-2][31:0];
            r_state       <= ST_DONE;
          end
        end
        ST_DIV_PREP: begin
          r_q_neg <= r_a[31] ^ r_b[31];
          r_r_neg <= r_a[31];
          // Corner cases skip the iterations but still use the fix slot, giving a 2-cycle latency.
          if (w_div_zero) begin
            r_special <= 1'b1;
            r_spec_q  <= 32'hFFFF_FFFF;
            r_spec_r  <= r_a;
            r_state   <= ST_DIV_FIX;
          end else if (w_div_ovf) begin
            r_special <= 1'b1;
            r_spec_q  <= 32'h8000_0000;
            r_spec_r  <= 32'd0;
            r_state   <= ST_DIV_FIX;
          end else begin
            r_special <= 1'b0;
            r_state   <= ST_DIV_ITER;
          end
        end
        ST_DIV_ITER: begin
          if (w_div_done_c || !w_div_busy) begin
            r_state <= ST_DIV_FIX;
          end
        end
        ST_DIV_FIX: begin
          r_resp_valid <= 1'b1;
          r_resp.wid   <= r_wid;
          if (r_special) begin
            r_resp.result <= (r_op == MDU_DIV) ? r_spec_q : r_spec_r;
          end else begin
            r_resp.result <= (r_op == MDU_DIV) ? w_fix_quo : w_fix_rem;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = (r_state == ST_IDLE);
  assign resp_valid_o = r_resp_valid;
  assign resp_o       = r_resp;

endmodule

// File: tb/tb_wired_mdu_unit.sv
// Self-checking bench for wired_mdu_unit: directed vector table, randomized ops vs. arithmetic model, abort sequences.
module tb_wired_mdu_unit;
  import wired_mdu_unit_pkg::*;

  localparam int DBI     = 1;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 2 + 32 / DBI;

  logic         clk;
  logic         rst;
  logic         flush_i;
  logic         req_valid_i;
  logic         req_ready_o;
  iq_mdu_req_t  req_i;
  logic         resp_valid_o;
  logic         resp_ready_i;
  iq_mdu_resp_t resp_o;

  int n_cmp = 0;
  int n_bad = 0;

  wired_mdu_unit #(
    .DIV_BITS_PER_ITER (DBI),
    .MUL_LATENCY       (MUL_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_i        (req_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_o       (resp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed 64-bit arithmetic with the architectural corner-case results.
  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    case (op)
      2'b00: return p[31:0];
      2'b01: return p[63:32];
      default: begin
        if (b == 32'd0) return (op == 2'b10) ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == 2'b10) ? 32'h8000_0000 : 32'd0;
        p = (op == 2'b10) ? (sa / sb) : (sa % sb);
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[1]) return MUL_LAT;
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return DIV_LAT;
  endfunction

  // Issue one op, measure latency, hold backpressure for 'hold' cycles, then complete the handshake.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input rob_rid_t wid, input int hold, input logic [31:0] exp_res,
                        input int exp_lat, input string tag);
    iq_mdu_resp_t cap;
    int lat;
    check({tag, "_ready_in"}, 64'(req_ready_o), 64'd1);
    resp_ready_i = (hold == 0);
    req_i = '{op: op, r0: a, r1: b, wid: wid};
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat = 0;
    while (!resp_valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (!resp_valid_o) return;
    cap = resp_o;
    check({tag, "_res"}, 64'(cap.result), 64'(exp_res));
    check({tag, "_wid"}, 64'(cap.wid), 64'(wid));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold"}, 64'({resp_valid_o, req_ready_o, resp_o}), 64'({1'b1, 1'b0, cap}));
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    check({tag, "_after_hs"}, 64'({resp_valid_o, req_ready_o}), 64'(2'b01));
  endtask

  task automatic watch_no_resp(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (resp_valid_o) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    rob_rid_t    wid;
    int          hold;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst          = 1'b1;
    flush_i      = 1'b0;
    req_valid_i  = 1'b0;
    req_i        = '0;
    resp_ready_i = 1'b1;

    // Directed table: hand-derived results and latencies.
    vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFD, 6'd5,  0,  32'hFFFF_FFEB, 2});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 6'd6,  0,  32'h4000_0000, 2});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 6'd7,  0,  32'h0000_0000, 2});
    vecs.push_back('{2'b01, 32'd7,          32'hFFFF_FFFD, 6'd8,  0,  32'hFFFF_FFFF, 2});
    vecs.push_back('{2'b01, 32'h0001_0000, 32'h0001_0000, 6'd9,  0,  32'h0000_0001, 2});
    vecs.push_back('{2'b00, 32'd11,         32'd13,        6'd10, 10, 32'd143,       2});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         6'd11, 0,  32'hFFFF_FFFD, 34});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'd2,         6'd12, 0,  32'hFFFF_FFFF, 34});
    vecs.push_back('{2'b10, 32'd100,        32'd7,         6'd13, 3,  32'd14,        34});
    vecs.push_back('{2'b11, 32'd100,        32'd7,         6'd14, 0,  32'd2,         34});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE, 6'd15, 0,  32'hFFFF_FFFD, 34});
    vecs.push_back('{2'b11, 32'd7,          32'hFFFF_FFFE, 6'd16, 0,  32'd1,         34});
    vecs.push_back('{2'b10, 32'd5,          32'd0,         6'd17, 0,  32'hFFFF_FFFF, 2});
    vecs.push_back('{2'b11, 32'd5,          32'd0,         6'd18, 0,  32'd5,         2});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd19, 0,  32'h8000_0000, 2});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 6'd20, 0,  32'd0,         2});

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(req_ready_o), 64'd1);
    check("reset_valid", 64'(resp_valid_o), 64'd0);
    check("reset_resp", 64'(resp_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wid, vecs[i].hold,
             vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Randomized ops against the arithmetic model, biased toward divide corner cases.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 20));
      if (sel == 3) a = 32'($urandom_range(0, 1000));
      if (sel == 4) b = -32'($urandom_range(1, 20));
      run_op(op, a, b, rob_rid_t'($urandom), $urandom_range(0, 2),
             model_res(op, a, b), model_lat(op, a, b), $sformatf("rnd%0d", n));
    end

    // Flush during the 10th divide iteration: no response, unit ready again next cycle.
    req_i = '{op: MDU_DIV, r0: 32'd100, r1: 32'd7, wid: 6'd33};
    req_valid_i = 1'b1;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy", 64'(req_ready_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_ready", 64'({req_ready_o, resp_valid_o}), 64'(2'b10));
    watch_no_resp(40, "flush_no_resp");
    run_op(MDU_MUL, 32'd3, 32'd4, 6'd21, 0, 32'd12, MUL_LAT, "post_flush");

    // Flush while a response is waiting and the consumer is ready in the same cycle.
    req_i = '{op: MDU_MUL, r0: 32'd6, r1: 32'd7, wid: 6'd22};
    req_valid_i = 1'b1;
    resp_ready_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat (MUL_LAT) @(posedge clk);
    #1;
    check("done_flush_pre", 64'(resp_valid_o), 64'd1);
    flush_i = 1'b1;
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("done_flush", 64'({req_ready_o, resp_valid_o}), 64'(2'b10));

    // Flush together with a request in IDLE: the request is dropped.
    req_i = '{op: MDU_MUL, r0: 32'd2, r1: 32'd2, wid: 6'd23};
    req_valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    flush_i = 1'b0;
    check("flush_vs_accept", 64'(req_ready_o), 64'd1);
    watch_no_resp(5, "flush_vs_accept_no_resp");

    // Asynchronous reset mid-multiply forces reset values without waiting for a clock edge.
    req_i = '{op: MDU_MUL, r0: 32'd5, r1: 32'd5, wid: 6'd24};
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("rst_busy", 64'(req_ready_o), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 64'({req_ready_o, resp_valid_o, resp_o}), 64'({1'b1, 1'b0, 38'd0}));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    watch_no_resp(10, "rst_no_resp");
    run_op(MDU_MUL, 32'd3, 32'd4, 6'd25, 0, 32'd12, MUL_LAT, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
